// File: rtl/wbu.sv
// ---------------------------------------------------------------------------
// wbu -- write-back unit
//
// Merges two result sources onto a single register-file write port:
//   * ALU results, buffered in a 2-entry FIFO with valid/ready handshake
//   * load results from the LSU, which have no back-pressure and always win
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   alu_valid/ready     ALU handshake (accepted on valid & ready at clk rise)
//   alu_rd/wen/data     ALU destination, write request, result
//   lsu_valid           load data present this cycle (always consumed)
//   lsu_rd/funct3       load destination and load type
//   lsu_addr_lo         byte offset of the load within the aligned word
//   lsu_rdata           raw aligned word from memory
//   waddr/wdata/wen     register-file write port (combinational)
//   retire_cnt          running count of consumed results, wraps at 2^32
// ---------------------------------------------------------------------------
module wbu #(
  parameter int DATA_WIDTH  = 32,
  parameter int REG_NUM_BIT = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [REG_NUM_BIT-1:0] alu_rd,
  input  logic                   alu_wen,
  input  logic [DATA_WIDTH-1:0]  alu_data,
  input  logic                   lsu_valid,
  input  logic [REG_NUM_BIT-1:0] lsu_rd,
  input  logic [2:0]             lsu_funct3,
  input  logic [1:0]             lsu_addr_lo,
  input  logic [DATA_WIDTH-1:0]  lsu_rdata,
  output logic [REG_NUM_BIT-1:0] waddr,
  output logic [DATA_WIDTH-1:0]  wdata,
  output logic                   wen,
  output logic [31:0]            retire_cnt
);

  logic [REG_NUM_BIT-1:0] fifo_rd   [2];
  logic                   fifo_wen  [2];
  logic [DATA_WIDTH-1:0]  fifo_data [2];
  logic                   rd_ptr;
  logic                   wr_ptr;
  logic [1:0]             count;

  logic push;
  logic pop;
  logic lsu_take;

  // Ready does not look at this cycle's pop: a full FIFO stalls the ALU
  // for one cycle even when the head is leaving.
  assign alu_ready = !rst && (count < 2'd2);
  assign push      = alu_valid && alu_ready;
  assign lsu_take  = !rst && lsu_valid;
  assign pop       = !rst && !lsu_valid && (count != 2'd0);

  // Load data formatting
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_data;

  always_comb begin
    byte_sel = 8'h00;
    case (lsu_addr_lo)
      2'd0: byte_sel = lsu_rdata[7:0];
      2'd1: byte_sel = lsu_rdata[15:8];
      2'd2: byte_sel = lsu_rdata[23:16];
      2'd3: byte_sel = lsu_rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    // Halfword loads only look at addr_lo[1]; bit 0 is ignored.
    half_sel = lsu_addr_lo[1] ? lsu_rdata[31:16] : lsu_rdata[15:0];

    load_data = lsu_rdata;
    case (lsu_funct3)
      3'b000:  load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: load_data = lsu_rdata;
    endcase
  end

  // Write port mux; writes to x0 or entries without a write request are
  // suppressed but still consumed.
  always_comb begin
    waddr = '0;
    wdata = '0;
    wen   = 1'b0;
    if (lsu_take) begin
      waddr = lsu_rd;
      wdata = load_data;
      wen   = (lsu_rd != '0);
    end else if (pop) begin
      waddr = fifo_rd[rd_ptr];
      wdata = fifo_data[rd_ptr];
      wen   = fifo_wen[rd_ptr] && (fifo_rd[rd_ptr] != '0);
    end
  end

  // Entry storage needs no reset: occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= alu_rd;
      fifo_wen[wr_ptr]  <= alu_wen;
      fifo_data[wr_ptr] <= alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      retire_cnt <= 32'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (lsu_take || pop) retire_cnt <= retire_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_wbu.sv
module tb_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic        alu_wen;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_addr_lo;
  logic [31:0] lsu_rdata;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        wen;
  logic [31:0] retire_cnt;

  wbu #(.DATA_WIDTH(32), .REG_NUM_BIT(5)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_wen(alu_wen), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_funct3(lsu_funct3),
    .lsu_addr_lo(lsu_addr_lo), .lsu_rdata(lsu_rdata),
    .waddr(waddr), .wdata(wdata), .wen(wen), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned rd;
    bit          wr;
    int unsigned data;
  } ent_t;

  ent_t        q[$];
  int unsigned m_cnt;
  int          vectors;
  int          miscompares;

  logic        obs_ready;
  logic        obs_wen;
  logic [4:0]  obs_waddr;
  logic [31:0] obs_wdata;
  logic [31:0] obs_cnt;

  // Reference load formatting done with plain arithmetic on the word.
  function automatic int unsigned fmt_load(int unsigned f3, int unsigned lo, int unsigned w);
    int unsigned b, h;
    b = (w >> (8 * lo)) % 256;
    h = (w >> (16 * (lo / 2))) % 65536;
    case (f3)
      0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      4: return b;
      5: return h;
      default: return w;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic cycle(input bit r, input bit av, input int unsigned ard, input bit awr,
                       input int unsigned adata, input bit lv, input int unsigned lrd,
                       input int unsigned f3, input int unsigned lo, input int unsigned rdata);
    bit          e_ready, e_wen, popping;
    int unsigned e_addr, e_data;
    ent_t        ne;
    @(negedge clk);
    rst = r; alu_valid = av; alu_rd = 5'(ard); alu_wen = awr; alu_data = adata;
    lsu_valid = lv; lsu_rd = 5'(lrd); lsu_funct3 = 3'(f3); lsu_addr_lo = 2'(lo);
    lsu_rdata = rdata;
    #1;
    e_ready = !r && (q.size() < 2);
    popping = !r && !lv && (q.size() > 0);
    e_wen = 0; e_addr = 0; e_data = 0;
    if (!r && lv) begin
      e_wen = (lrd != 0); e_addr = lrd; e_data = fmt_load(f3, lo, rdata);
    end else if (popping) begin
      e_wen = q[0].wr && (q[0].rd != 0); e_addr = q[0].rd; e_data = q[0].data;
    end
    obs_ready = alu_ready; obs_wen = wen; obs_waddr = waddr;
    obs_wdata = wdata; obs_cnt = retire_cnt;
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, e_ready});
    chk("wen", {31'd0, wen}, {31'd0, e_wen});
    chk("retire_cnt", retire_cnt, m_cnt);
    if (e_wen) begin
      chk("waddr", {27'd0, waddr}, e_addr);
      chk("wdata", wdata, e_data);
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (lv || popping) m_cnt = m_cnt + 1;
      if (popping) void'(q.pop_front());
      if (av && e_ready) begin
        ne.rd = ard; ne.wr = awr; ne.data = adata;
        q.push_back(ne);
      end
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int unsigned c0;
    vectors = 0; miscompares = 0; m_cnt = 0;
    rst = 1; alu_valid = 0; alu_rd = 0; alu_wen = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_funct3 = 0; lsu_addr_lo = 0; lsu_rdata = 0;

    // Reset, with both sources active to show they are ignored
    cycle(1, 1, 3, 1, 32'h1111_1111, 1, 4, 2, 0, 32'hDEAD_BEEF);
    chk("rst_wen", {31'd0, obs_wen}, 32'd0);
    chk("rst_ready", {31'd0, obs_ready}, 32'd0);
    idle();
    chk("post_rst_cnt", obs_cnt, 32'd0);
    chk("post_rst_ready", {31'd0, obs_ready}, 32'd1);

    // Single ALU push, no bypass, then write next cycle
    cycle(0, 1, 5, 1, 32'h1234_5678, 0, 0, 0, 0, 0);
    chk("nobypass_wen", {31'd0, obs_wen}, 32'd0);
    idle();
    chk("alu_wen", {31'd0, obs_wen}, 32'd1);
    chk("alu_waddr", {27'd0, obs_waddr}, 32'd5);
    chk("alu_wdata", obs_wdata, 32'h1234_5678);
    idle();
    chk("alu_cnt", obs_cnt, 32'd1);

    // Load formatting corner cases
    cycle(0, 0, 0, 0, 0, 1, 9, 0, 3, 32'h80FF_0000);
    chk("lb_wdata", obs_wdata, 32'hFFFF_FF80);
    cycle(0, 0, 0, 0, 0, 1, 9, 5, 2, 32'h80FF_0000);
    chk("lhu_wdata", obs_wdata, 32'h0000_80FF);
    cycle(0, 0, 0, 0, 0, 1, 9, 1, 3, 32'h80FF_0000);
    chk("lh_lo1_wdata", obs_wdata, 32'hFFFF_80FF);
    cycle(0, 0, 0, 0, 0, 1, 9, 2, 3, 32'h80FF_0000);
    chk("lw_wdata", obs_wdata, 32'h80FF_0000);

    // LSU priority with FIFO filling up, then ALU drains in order
    cycle(0, 1, 10, 1, 32'hA, 1, 1, 2, 0, 32'h100);
    cycle(0, 1, 11, 1, 32'hB, 1, 2, 2, 0, 32'h200);
    cycle(0, 1, 12, 1, 32'hC, 1, 3, 2, 0, 32'h300);
    chk("full_ready", {31'd0, obs_ready}, 32'd0);
    chk("lsu_wins_addr", {27'd0, obs_waddr}, 32'd3);
    idle();
    chk("drain0_addr", {27'd0, obs_waddr}, 32'd10);
    idle();
    chk("drain1_addr", {27'd0, obs_waddr}, 32'd11);
    idle();
    chk("drained_wen", {31'd0, obs_wen}, 32'd0);

    // Suppressed writes still retire
    c0 = obs_cnt;
    cycle(0, 1, 0, 1, 32'h55, 0, 0, 0, 0, 0);
    cycle(0, 1, 7, 0, 32'h66, 0, 0, 0, 0, 0);
    chk("rd0_wen", {31'd0, obs_wen}, 32'd0);
    idle();
    chk("nowen_wen", {31'd0, obs_wen}, 32'd0);
    idle();
    chk("suppress_cnt", obs_cnt - c0, 32'd2);

    // Reset mid-operation with two entries queued
    cycle(0, 1, 20, 1, 32'h20, 1, 0, 2, 0, 0);
    cycle(0, 1, 21, 1, 32'h21, 1, 0, 2, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("midrst_wen", {31'd0, obs_wen}, 32'd0);
    idle();
    chk("midrst_cnt", obs_cnt, 32'd0);
    chk("midrst_ready", {31'd0, obs_ready}, 32'd1);
    chk("midrst_nostale", {31'd0, obs_wen}, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(99) < 2, $urandom_range(99) < 60, $urandom_range(31),
            $urandom_range(3) != 0, $urandom, $urandom_range(99) < 40,
            $urandom_range(31), $urandom_range(7), $urandom_range(3), $urandom);
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
